// File: rtl/register_bank_arbiter_if.sv
// rtl/register_bank_arbiter_if.sv - requester-side bus of the register bank arbiter
interface register_bank_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] wdata;
    logic [NREQ-1:0]       lock;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      rdata;

    modport master (
        output req, op, wdata, lock,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, op, wdata, lock,
        output gnt, done, rdata
    );
endinterface

// File: rtl/register_bank_arbiter.sv
// rtl/register_bank_arbiter.sv - round-robin arbiter/sequencer for one register_bank
// Optional grant locking for back-to-back ops: define REGBANK_ARB_LOCK_EN.
module register_bank_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    register_bank_arbiter_if.slave rq,
    output logic [WIDTH-1:0]     bank_d,
    output logic [WIDTH-1:0]     bank_sdata,
    output logic                 bank_ena,
    output logic                 bank_sload,
    output logic                 bank_sclr,
    input  logic [WIDTH-1:0]     bank_q
);
    localparam int IDXW = $clog2(NREQ);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SLOAD = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_n;
    logic [IDXW-1:0]  idx_q, idx_n;
    logic [IDXW-1:0]  last_q, last_n;
    logic [1:0]       op_q, op_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic [NREQ-1:0]  gnt_q, gnt_n;
    logic [NREQ-1:0]  done_q, done_n;
    logic [WIDTH-1:0] rdata_q, rdata_n;
    logic [WIDTH-1:0] bank_d_q, bank_d_n;
    logic [WIDTH-1:0] bank_sdata_q, bank_sdata_n;
    logic             ena_q, ena_n;
    logic             sload_q, sload_n;
    logic             sclr_q, sclr_n;

    logic [IDXW-1:0]  pick;
    logic [IDXW-1:0]  cand;
    logic             launch;
    logic [IDXW-1:0]  launch_idx;

    // Scan from farthest to nearest so the first set request after last_q wins.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDXW'((int'(last_q) + k) % NREQ);
            if (rq.req[cand]) begin
                pick = cand;
            end
        end
    end

    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        last_n       = last_q;
        op_n         = op_q;
        data_n       = data_q;
        gnt_n        = gnt_q;
        done_n       = '0;
        rdata_n      = rdata_q;
        bank_d_n     = bank_d_q;
        bank_sdata_n = bank_sdata_q;
        ena_n        = 1'b0;
        sload_n      = 1'b0;
        sclr_n       = 1'b0;
        launch       = 1'b0;
        launch_idx   = idx_q;

        case (state_q)
            IDLE: begin
                if (|rq.req) begin
                    launch     = 1'b1;
                    launch_idx = pick;
                end
            end
            ISSUE: begin
                done_n  = NREQ'(1) << idx_q;
                state_n = DONE;
            end
            DONE: begin
                rdata_n = bank_q;
                gnt_n   = '0;
                state_n = IDLE;
`ifdef REGBANK_ARB_LOCK_EN
                if (rq.lock[idx_q] && rq.req[idx_q]) begin
                    launch     = 1'b1;
                    launch_idx = idx_q;
                end else begin
                    last_n = idx_q;
                end
`else
                last_n = idx_q;
`endif
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase

        // Bank controls are registered so they are live for exactly the ISSUE cycle.
        if (launch) begin
            idx_n   = launch_idx;
            op_n    = rq.op[2*int'(launch_idx) +: 2];
            data_n  = rq.wdata[int'(launch_idx)*WIDTH +: WIDTH];
            gnt_n   = NREQ'(1) << launch_idx;
            state_n = ISSUE;
            case (op_n)
                OP_LOAD: begin
                    ena_n    = 1'b1;
                    bank_d_n = data_n;
                end
                OP_SLOAD: begin
                    ena_n        = 1'b1;
                    sload_n      = 1'b1;
                    bank_sdata_n = data_n;
                end
                OP_CLEAR: begin
                    ena_n  = 1'b1;
                    sclr_n = 1'b1;
                end
                default: begin
                    ena_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_q       <= IDXW'(NREQ - 1);
            op_q         <= '0;
            data_q       <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            bank_d_q     <= '0;
            bank_sdata_q <= '0;
            ena_q        <= 1'b0;
            sload_q      <= 1'b0;
            sclr_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            last_q       <= last_n;
            op_q         <= op_n;
            data_q       <= data_n;
            gnt_q        <= gnt_n;
            done_q       <= done_n;
            rdata_q      <= rdata_n;
            bank_d_q     <= bank_d_n;
            bank_sdata_q <= bank_sdata_n;
            ena_q        <= ena_n;
            sload_q      <= sload_n;
            sclr_q       <= sclr_n;
        end
    end

    assign rq.gnt     = gnt_q;
    assign rq.done    = done_q;
    // The bank updates on the ISSUE edge, so its output is already current in DONE.
    assign rq.rdata   = (state_q == DONE) ? bank_q : rdata_q;
    assign bank_d     = bank_d_q;
    assign bank_sdata = bank_sdata_q;
    assign bank_ena   = ena_q;
    assign bank_sload = sload_q;
    assign bank_sclr  = sclr_q;
endmodule

// File: tb/tb_register_bank_arbiter.sv
// tb/tb_register_bank_arbiter.sv - scoreboard bench for register_bank_arbiter with a bank model
module tb_register_bank_arbiter;
    localparam int WIDTH = 16;
    localparam int NREQ  = 4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SLOAD = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] bank_d;
    logic [WIDTH-1:0] bank_sdata;
    logic             bank_ena;
    logic             bank_sload;
    logic             bank_sclr;
    logic [WIDTH-1:0] bank_q = '0;

    always #5 clk = ~clk;

    register_bank_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) rq();

    register_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rq         (rq),
        .bank_d     (bank_d),
        .bank_sdata (bank_sdata),
        .bank_ena   (bank_ena),
        .bank_sload (bank_sload),
        .bank_sclr  (bank_sclr),
        .bank_q     (bank_q)
    );

    // register_bank stand-in: aclr tied off, sclr over sload over d
    always @(posedge clk) begin
        if (bank_ena) begin
            if (bank_sclr)       bank_q <= '0;
            else if (bank_sload) bank_q <= bank_sdata;
            else                 bank_q <= bank_d;
        end
    end

    typedef struct {
        int         idx;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] exp_bank = '0;
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_apply(input logic [1:0] opc, input logic [15:0] data);
        case (opc)
            OP_LOAD, OP_SLOAD: exp_bank = data;
            OP_CLEAR:          exp_bank = '0;
            default:           exp_bank = exp_bank;
        endcase
    endtask

    task automatic set_req(input int i, input logic [1:0] opc, input logic [15:0] data);
        rq.req[i]             = 1'b1;
        rq.op[2*i +: 2]       = opc;
        rq.wdata[16*i +: 16]  = data;
    endtask

    task automatic wait_new_gnt(output bit ok);
        bit seen_low;
        seen_low = (rq.gnt == '0);
        ok = 1'b0;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (rq.gnt == '0) seen_low = 1'b1;
            else if (seen_low) begin
                ok = 1'b1;
                break;
            end
        end
        check("gnt_wait", 32'(ok), 1);
    endtask

    task automatic do_op(input int i, input logic [1:0] opc, input logic [15:0] data);
        bit ok;
        set_req(i, opc, data);
        wait_new_gnt(ok);
        if (ok) begin
            check("op_gnt", rq.gnt, 32'(1) << i);
            model_apply(opc, data);
            sb.push_back('{i, exp_bank});
            check("op_ena", bank_ena, 32'(opc != OP_READ));
            check("op_sload", bank_sload, 32'(opc == OP_SLOAD));
            check("op_sclr", bank_sclr, 32'(opc == OP_CLEAR));
            if (opc == OP_LOAD)  check("op_bank_d", bank_d, data);
            if (opc == OP_SLOAD) check("op_bank_sdata", bank_sdata, data);
            rq.req[i] = 1'b0;
            @(negedge clk);
            check("op_done_lat", rq.done, 32'(1) << i);
            check("op_gnt_in_done", rq.gnt, 32'(1) << i);
            @(negedge clk);
            check("op_ena_after", bank_ena, 0);
            check("op_rdata_hold", rq.rdata, exp_bank);
        end
    endtask

    // Output monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        check("gnt_onehot", 32'($onehot0(rq.gnt)), 1);
        check("done_onehot", 32'($onehot0(rq.done)), 1);
        if (rq.done != '0) begin
            if (sb.size() == 0) begin
                check("done_unexpected", rq.done, 0);
            end else begin
                mon_e = sb.pop_front();
                check("done_idx", rq.done, 32'(1) << mon_e.idx);
                check("done_rdata", rq.rdata, mon_e.data);
            end
        end
    end

    initial begin
        bit ok;
        int prev_cyc;
        rq.req   = '0;
        rq.op    = '0;
        rq.wdata = '0;
        rq.lock  = '0;
        prev_cyc = 0;

        // reset with all requesters asking to read
        rst_n  = 1'b0;
        rq.req = 4'b1111;
        rq.op  = 8'hFF;
        repeat (2) @(negedge clk);
        check("rst_gnt", rq.gnt, 0);
        check("rst_done", rq.done, 0);
        check("rst_ena", bank_ena, 0);
        check("rst_rdata", rq.rdata, 0);
        rst_n = 1'b1;

        // round robin from reset: 0,1,2,3,0 at 3-cycle spacing
        for (int k = 0; k < 5; k++) begin
            wait_new_gnt(ok);
            check("rr_gnt", rq.gnt, 32'(1) << (k % NREQ));
            sb.push_back('{k % NREQ, exp_bank});
            if (k > 0) check("rr_spacing", cyc - prev_cyc, 3);
            prev_cyc = cyc;
            if (k == 4) rq.req = '0;
        end
        repeat (2) @(negedge clk);

        do_op(2, OP_LOAD, 16'hA5A5);
        do_op(1, OP_SLOAD, 16'h1234);
        do_op(1, OP_CLEAR, 16'hBEEF);
        do_op(3, OP_READ, 16'h0000);

        // reset in the middle of an op: no done, everything back to zero
        set_req(0, OP_LOAD, 16'hFFFF);
        wait_new_gnt(ok);
        check("abort_gnt", rq.gnt, 1);
        check("abort_ena", bank_ena, 1);
        rst_n  = 1'b0;
        rq.req = '0;
        @(negedge clk);
        check("abort_gnt_clr", rq.gnt, 0);
        check("abort_done", rq.done, 0);
        check("abort_ena_clr", bank_ena, 0);
        check("abort_bank_d", bank_d, 0);
        check("abort_bank_sdata", bank_sdata, 0);
        check("abort_rdata", rq.rdata, 0);
        @(negedge clk);
        check("abort_done2", rq.done, 0);
        rst_n = 1'b1;

        do_op(3, OP_LOAD, 16'h0F0F);
        do_op(0, OP_READ, 16'h0000);

`ifdef REGBANK_ARB_LOCK_EN
        rq.lock[3] = 1'b1;
        set_req(3, OP_LOAD, 16'h1111);
        set_req(0, OP_READ, 16'h0000);
        wait_new_gnt(ok);
        check("lock_gnt1", rq.gnt, 4'b1000);
        check("lock_d1", bank_d, 16'h1111);
        model_apply(OP_LOAD, 16'h1111);
        sb.push_back('{3, exp_bank});
        rq.wdata[48 +: 16] = 16'h2222;
        @(negedge clk);
        check("lock_done1", rq.done, 4'b1000);
        model_apply(OP_LOAD, 16'h2222);
        sb.push_back('{3, exp_bank});
        @(negedge clk);
        check("lock_gnt2", rq.gnt, 4'b1000);
        check("lock_ena2", bank_ena, 1);
        check("lock_d2", bank_d, 16'h2222);
        rq.wdata[48 +: 16] = 16'h3333;
        @(negedge clk);
        check("lock_done2", rq.done, 4'b1000);
        model_apply(OP_LOAD, 16'h3333);
        sb.push_back('{3, exp_bank});
        @(negedge clk);
        check("lock_d3", bank_d, 16'h3333);
        rq.lock[3] = 1'b0;
        rq.req[3]  = 1'b0;
        @(negedge clk);
        check("lock_done3", rq.done, 4'b1000);
        wait_new_gnt(ok);
        check("lock_release_gnt", rq.gnt, 4'b0001);
        sb.push_back('{0, exp_bank});
        rq.req = '0;
        repeat (2) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
